// File: rtl/wb_uart_master.sv
// Serial-to-Wishbone bridge: parses 'W'/'R' host frames from the uart engine and runs single 32-bit bus cycles.
// Optional bus watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_uart_master #(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        rx_error,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR,
    S_DAT,
    S_BUS,
    S_REPLY
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rep_q;
  logic [2:0]  rep_cnt_q;
  logic        rx_ack_q;
  logic [7:0]  tx_data_q;
  logic        tx_wr_q;
`ifdef WBM_TIMEOUT_EN
  logic [15:0] to_q;
`endif

  // rx_ack_q doubles as the hold cycle: the engine still shows the old byte then.
  logic byte_take;
  assign byte_take = rx_avail && !rx_ack_q &&
                     (state_q == S_IDLE || state_q == S_ADR || state_q == S_DAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      rep_q     <= 32'h0;
      rep_cnt_q <= 3'd0;
      rx_ack_q  <= 1'b0;
      tx_data_q <= 8'h0;
      tx_wr_q   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      to_q      <= 16'd0;
`endif
    end else begin
      rx_ack_q <= 1'b0;
      tx_wr_q  <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      if (state_q != S_BUS)
        to_q <= 16'd0;
`endif
      case (state_q)
        S_IDLE: begin
          if (byte_take) begin
            rx_ack_q <= 1'b1;
            cnt_q    <= 2'd0;
            if (!rx_error && (rx_data == CMD_W || rx_data == CMD_R)) begin
              we_q    <= (rx_data == CMD_W);
              state_q <= S_ADR;
            end else begin
              rep_q     <= {NAK_BYTE, 24'h0};
              rep_cnt_q <= 3'd1;
              state_q   <= S_REPLY;
            end
          end
        end
        S_ADR: begin
          if (byte_take) begin
            rx_ack_q <= 1'b1;
            if (rx_error) begin
              cnt_q     <= 2'd0;
              rep_q     <= {NAK_BYTE, 24'h0};
              rep_cnt_q <= 3'd1;
              state_q   <= S_REPLY;
            end else begin
              adr_q <= {adr_q[23:0], rx_data};
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3)
                state_q <= we_q ? S_DAT : S_BUS;
            end
          end
        end
        S_DAT: begin
          if (byte_take) begin
            rx_ack_q <= 1'b1;
            if (rx_error) begin
              cnt_q     <= 2'd0;
              rep_q     <= {NAK_BYTE, 24'h0};
              rep_cnt_q <= 3'd1;
              state_q   <= S_REPLY;
            end else begin
              dat_q <= {dat_q[23:0], rx_data};
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3)
                state_q <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // The entry cycle only raises cyc; ack is honoured once the cycle is on the bus.
          if (!cyc_q) begin
            cyc_q <= 1'b1;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= S_REPLY;
            if (we_q) begin
              rep_q     <= {ACK_BYTE, 24'h0};
              rep_cnt_q <= 3'd1;
            end else begin
              rep_q     <= wb_dat_i;
              rep_cnt_q <= 3'd4;
            end
`ifdef WBM_TIMEOUT_EN
          end else if (to_q == 16'(TIMEOUT_CYC - 1)) begin
            cyc_q     <= 1'b0;
            rep_q     <= {NAK_BYTE, 24'h0};
            rep_cnt_q <= 3'd1;
            state_q   <= S_REPLY;
          end else begin
            to_q <= to_q + 16'd1;
`endif
          end
        end
        S_REPLY: begin
          // tx_wr_q marks the cycle before tx_busy reflects the byte just issued.
          if (!tx_busy && !tx_wr_q) begin
            tx_data_q <= rep_q[31:24];
            tx_wr_q   <= 1'b1;
            rep_q     <= {rep_q[23:0], 8'h00};
            rep_cnt_q <= rep_cnt_q - 3'd1;
            if (rep_cnt_q == 3'd1)
              state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign rx_ack   = rx_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;

endmodule
